// File: rtl/ex_divider.sv
`default_nettype none
// ============================================================================
// Module   : ex_divider
// Purpose  : Iterative restoring radix-2 divider for DIV/DIVU in the EX stage.
// Revision : 1.0 - initial release
// ============================================================================
module ex_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] opr1,
  input  logic [DATA_W-1:0] opr2,
  input  logic              cancel,
  input  logic              hold,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  localparam int               CNT_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int               PR_W      = 2 * DATA_W + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [PR_W-1:0]     pr_q,       pr_d;
  logic [DATA_W-1:0]   divisor_q,  divisor_d;
  logic                quot_neg_q, quot_neg_d;
  logic                rem_neg_q,  rem_neg_d;
  logic [DATA_W-1:0]   quot_q,     quot_d;
  logic [DATA_W-1:0]   rem_q,      rem_d;

  logic                stall_c;
  logic [DATA_W-1:0]   opr1_abs;
  logic [DATA_W-1:0]   opr2_abs;
  logic [PR_W-1:0]     pr_shift;
  logic [DATA_W+1:0]   trial;
  logic [PR_W-1:0]     pr_step;
  logic [DATA_W-1:0]   quot_mag;
  logic [DATA_W-1:0]   rem_mag;

  // Magnitudes; the most negative value maps onto itself, which is correct as unsigned.
  always_comb begin
    opr1_abs = (signed_op && opr1[DATA_W-1]) ? -opr1 : opr1;
    opr2_abs = (signed_op && opr2[DATA_W-1]) ? -opr2 : opr2;
  end

  // One restoring step: shift left, try subtracting the divisor from the upper half.
  always_comb begin
    pr_shift = pr_q << 1;
    trial    = {1'b0, pr_shift[PR_W-1:DATA_W]} - {2'b00, divisor_q};
    if (!trial[DATA_W+1]) begin
      pr_step = {trial[DATA_W:0], pr_shift[DATA_W-1:1], 1'b1};
    end else begin
      pr_step = pr_shift;
    end
    quot_mag = pr_step[DATA_W-1:0];
    rem_mag  = pr_step[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pr_d       = pr_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    stall_c    = 1'b0;

    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            stall_c    = 1'b1;
            pr_d       = {{(DATA_W+1){1'b0}}, opr1_abs};
            divisor_d  = opr2_abs;
            quot_neg_d = signed_op & (opr1[DATA_W-1] ^ opr2[DATA_W-1]);
            rem_neg_d  = signed_op & opr1[DATA_W-1];
            cnt_d      = '0;
            if (opr2 == '0) begin
              // Divide by zero completes at once with a fixed, non-trapping result.
              state_d = S_DONE;
              quot_d  = '1;
              rem_d   = opr1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          stall_c = 1'b1;
          pr_d    = pr_step;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            quot_d  = quot_neg_q ? -quot_mag : quot_mag;
            rem_d   = rem_neg_q  ? -rem_mag  : rem_mag;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // start is deliberately ignored here so a held instruction cannot re-issue.
          if (!hold) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pr_q       <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pr_q       <= pr_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

  assign stall_req = stall_c & ~rst;
  assign done      = (state_q == S_DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_divider
// Purpose  : Self-checking bench for ex_divider against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_divider;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              signed_op;
  logic [DATA_W-1:0] opr1;
  logic [DATA_W-1:0] opr2;
  logic              cancel;
  logic              hold;
  logic              stall_req;
  logic              done;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;

  int n_cmp = 0;
  int n_err = 0;

  ex_divider #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .opr1      (opr1),
    .opr2      (opr2),
    .cancel    (cancel),
    .hold      (hold),
    .stall_req (stall_req),
    .done      (done),
    .quot      (quot),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Truncating division on wide signed integers: quotient toward zero, remainder takes dividend sign.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      sa = s ? {{32{a[31]}}, a} : {32'd0, a};
      sb = s ? {{32{b[31]}}, b} : {32'd0, b};
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int nhold, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    int          cyc;
    int          stalls;
    int          lat;
    bit          seen;
    model(s, a, b, eq, er);
    @(negedge clk);
    start     = 1'b1;
    signed_op = s;
    opr1      = a;
    opr2      = b;
    hold      = 1'b0;
    cyc       = 0;
    stalls    = 0;
    seen      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall_req) stalls++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      lat = (b == 32'd0) ? 1 : DATA_W + 1;
      chk({tag, " latency"}, cyc, lat);
      chk({tag, " stall_cycles"}, stalls, lat);
      chk({tag, " quot"}, quot, eq);
      chk({tag, " rem"}, rem, er);
      chk({tag, " stall_in_done"}, {31'd0, stall_req}, 32'd0);
      hold = (nhold > 0);
      for (int i = 0; i < nhold; i++) begin
        @(negedge clk);
        #1;
        chk({tag, " hold_done"}, {31'd0, done}, 32'd1);
        chk({tag, " hold_stall"}, {31'd0, stall_req}, 32'd0);
        chk({tag, " hold_quot"}, quot, eq);
        chk({tag, " hold_rem"}, rem, er);
        if (i == nhold - 1) hold = 1'b0;
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      chk({tag, " post_done"}, {31'd0, done}, 32'd0);
      chk({tag, " post_stall"}, {31'd0, stall_req}, 32'd0);
    end else begin
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick_operand(input bit allow_zero);
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0001;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h7FFF_FFFF;
    specials[4] = 32'h0000_0000;
    case ($urandom_range(0, 5))
      0:       return specials[$urandom_range(0, allow_zero ? 4 : 3)];
      1:       return 32'($urandom_range(1, 15));
      2:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    bit          saw_done;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1; start = 1'b1; signed_op = 1'b0; opr1 = 32'd9; opr2 = 32'd3;
    cancel = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall", {31'd0, stall_req}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quot", quot, 32'd0);
    chk("reset rem", rem, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    run_op(1'b1, -32'd7, 32'd2, 0, "div_m7_2");
    run_op(1'b1, 32'd7, -32'd2, 1, "div_7_m2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu_min_m1");
    run_op(1'b0, 32'd5, 32'd0, 0, "divu_5_0");
    run_op(1'b1, -32'd9, 32'd0, 2, "div_m9_0");
    run_op(1'b0, 32'd1000, 32'd33, 3, "divu_hold3");
    run_op(1'b0, 32'd100, 32'd7, 0, "divu_after_hold");

    // Flush in RUN cycle 10: no completion, results keep the 100/7 values.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; opr1 = -32'd12345; opr2 = 32'd77;
    for (int i = 0; i < 10; i++) @(negedge clk);
    cancel = 1'b1;
    #1;
    chk("cancel stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("cancel no_done", {31'd0, saw_done}, 32'd0);
    chk("cancel quot", quot, 32'd14);
    chk("cancel rem", rem, 32'd2);

    // start and cancel together in IDLE never launch an operation.
    start = 1'b1; cancel = 1'b1; signed_op = 1'b0; opr1 = 32'd50; opr2 = 32'd3;
    #1;
    chk("start_cancel stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1;
    chk("start_cancel done", {31'd0, done}, 32'd0);
    chk("start_cancel stall_after", {31'd0, stall_req}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("start_cancel no_done", {31'd0, saw_done}, 32'd0);

    // Reset in the middle of RUN clears results immediately.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; opr1 = 32'd999; opr2 = 32'd4;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset quot", quot, 32'd0);
    chk("midreset rem", rem, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset stall", {31'd0, stall_req}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b1, -32'd100, -32'd7, 0, "div_after_reset");

    for (int k = 0; k < 30; k++) begin
      a = pick_operand(1'b1);
      b = pick_operand(($urandom_range(0, 5) == 0));
      run_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
